axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_arb_pkg.sv | 18 +
 rtl/axis_reg_slice.sv | 67 ++++++
 rtl/axis_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared definitions for the two-input AXI-Stream round-robin arbiter:
//   - default width constants for tdata and the packet statistics counters
//   - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package axis_arb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage : axis_arb_pkg

// File: rtl/axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// Single-stage AXI-Stream forward register slice. An accepted input beat shows
// up on the output one cycle later, unmodified; the output holds while the
// downstream stalls.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_valid, i_data, i_strb, i_last  upstream beat
//   o_ready                        slice can take a beat this cycle
//   o_m_valid, o_m_data,
//   o_m_strb, o_m_last             registered downstream beat
//   i_m_ready                      downstream ready
// -----------------------------------------------------------------------------
module axis_reg_slice
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    input  logic                    i_last,
    output logic                    o_ready,
    output logic                    o_m_valid,
    output logic [DATA_WIDTH-1:0]   o_m_data,
    output logic [DATA_WIDTH/8-1:0] o_m_strb,
    output logic                    o_m_last,
    input  logic                    i_m_ready
);

    logic                    r_valid;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH/8-1:0] r_strb;
    logic                    r_last;

    // Empty, or the held beat leaves this cycle: a new beat can be taken.
    assign o_ready = ~r_valid | i_m_ready;

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            // NOTE: the payload registers are reset too, because the output
            // bus must read all-zero while reset is asserted.
            r_data  <= '0;
            r_strb  <= '0;
            r_last  <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_strb  <= i_strb;
            r_last  <= i_last;
        end else if (i_m_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_m_valid = r_valid;
    assign o_m_data  = r_data;
    assign o_m_strb  = r_strb;
    assign o_m_last  = r_last;

endmodule : axis_reg_slice

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-locked round-robin arbiter merging two AXI-Stream requesters (s00,
// s01) onto one master stream (m00) through a one-stage register slice.
// A grant lasts until the granted requester's tlast beat is accepted; each new
// packet costs one IDLE cycle. Ties go to the requester not granted last.
//
// Ports:
//   axis_aclk, axis_aresetn          clock, asynchronous active-low reset
//   s0N_axis_tdata/tstrb/tvalid/tlast requester N beat
//   s0N_axis_tready                  requester N ready
//   m00_axis_tdata/tstrb/tvalid/tlast merged output beat (registered)
//   m00_axis_tready                  downstream ready
//   grant_id                         last granted requester (0 = s00, 1 = s01)
//   busy                             a packet is currently granted
//   pkt_cnt0, pkt_cnt1               completed-packet counts per requester
//
// Configuration:
//   AXIS_ARB_STATS_EN  defined   -> pkt_cntN count accepted tlast beats (wrap)
//                      undefined -> pkt_cntN tied to zero, no counter flops
// -----------------------------------------------------------------------------
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,

    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,

    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,

    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,

    output logic                    grant_id,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    pkt_cnt0,
    output logic [CNT_WIDTH-1:0]    pkt_cnt1
);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic                    r_last_grant;

    logic                    w_slice_ready;
    logic                    w_sel_valid;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [DATA_WIDTH/8-1:0] w_sel_strb;
    logic                    w_sel_last;

    // Next state, requester readies and the mux into the slice.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state    = r_state;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        w_sel_valid     = 1'b0;
        w_sel_data      = s00_axis_tdata;
        w_sel_strb      = s00_axis_tstrb;
        w_sel_last      = s00_axis_tlast;

        case (r_state)
            IDLE: begin
                // On a tie, hand the grant to whoever did not have it last.
                if (s00_axis_tvalid && s01_axis_tvalid)
                    w_next_state = r_last_grant ? GRANT0 : GRANT1;
                else if (s00_axis_tvalid)
                    w_next_state = GRANT0;
                else if (s01_axis_tvalid)
                    w_next_state = GRANT1;
            end
            GRANT0: begin
                s00_axis_tready = w_slice_ready;
                w_sel_valid     = s00_axis_tvalid;
                if (s00_axis_tvalid && w_slice_ready && s00_axis_tlast)
                    w_next_state = IDLE;
            end
            GRANT1: begin
                s01_axis_tready = w_slice_ready;
                w_sel_valid     = s01_axis_tvalid;
                w_sel_data      = s01_axis_tdata;
                w_sel_strb      = s01_axis_tstrb;
                w_sel_last      = s01_axis_tlast;
                if (s01_axis_tvalid && w_slice_ready && s01_axis_tlast)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;   // s00 wins the first tie after reset
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_next_state == GRANT0)
                r_last_grant <= 1'b0;
            else if (r_state == IDLE && w_next_state == GRANT1)
                r_last_grant <= 1'b1;
        end
    end

    assign busy     = (r_state == GRANT0) || (r_state == GRANT1);
    assign grant_id = r_last_grant;

    axis_reg_slice #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slice (
        .i_clk     (axis_aclk),
        .i_rst_n   (axis_aresetn),
        .i_valid   (w_sel_valid),
        .i_data    (w_sel_data),
        .i_strb    (w_sel_strb),
        .i_last    (w_sel_last),
        .o_ready   (w_slice_ready),
        .o_m_valid (m00_axis_tvalid),
        .o_m_data  (m00_axis_tdata),
        .o_m_strb  (m00_axis_tstrb),
        .o_m_last  (m00_axis_tlast),
        .i_m_ready (m00_axis_tready)
    );

`ifdef AXIS_ARB_STATS_EN
    logic                 w_done0;
    logic                 w_done1;
    logic [CNT_WIDTH-1:0] r_pkt_cnt0;
    logic [CNT_WIDTH-1:0] r_pkt_cnt1;

    // A packet completes when its tlast beat is accepted (readies are
    // already gated by the grant state).
    assign w_done0 = s00_axis_tvalid && s00_axis_tready && s00_axis_tlast;
    assign w_done1 = s01_axis_tvalid && s01_axis_tready && s01_axis_tlast;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            if (w_done0) r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
            if (w_done1) r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
        end
    end

    assign pkt_cnt0 = r_pkt_cnt0;
    assign pkt_cnt1 = r_pkt_cnt1;
`else
    assign pkt_cnt0 = '0;
    assign pkt_cnt1 = '0;
`endif

endmodule : axis_rr_arbiter

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed bench for axis_rr_arbiter. A second instance with CNT_WIDTH=2
// shares the stimulus so counter wrap can be observed. Output beats accepted
// downstream are logged with their cycle number; expectations are hand-written.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 16;

`ifdef AXIS_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] s_data  [2];
    logic [SW-1:0] s_strb  [2];
    logic          s_valid [2];
    logic          s_last  [2];
    logic          m_ready;

    logic          w_trdy [2];
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_strb;
    logic          m_valid, m_last;
    logic          grant_id, busy;
    logic [CW-1:0] cnt0, cnt1;

    logic          n_trdy0, n_trdy1, n_valid, n_last, n_gid, n_busy;
    logic [DW-1:0] n_data;
    logic [SW-1:0] n_strb;
    logic [1:0]    n_cnt0, n_cnt1;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .axis_aclk       (clk),
        .axis_aresetn    (rst_n),
        .s00_axis_tdata  (s_data[0]),
        .s00_axis_tstrb  (s_strb[0]),
        .s00_axis_tvalid (s_valid[0]),
        .s00_axis_tlast  (s_last[0]),
        .s00_axis_tready (w_trdy[0]),
        .s01_axis_tdata  (s_data[1]),
        .s01_axis_tstrb  (s_strb[1]),
        .s01_axis_tvalid (s_valid[1]),
        .s01_axis_tlast  (s_last[1]),
        .s01_axis_tready (w_trdy[1]),
        .m00_axis_tdata  (m_data),
        .m00_axis_tstrb  (m_strb),
        .m00_axis_tvalid (m_valid),
        .m00_axis_tlast  (m_last),
        .m00_axis_tready (m_ready),
        .grant_id        (grant_id),
        .busy            (busy),
        .pkt_cnt0        (cnt0),
        .pkt_cnt1        (cnt1)
    );

    axis_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_dut_w2 (
        .axis_aclk       (clk),
        .axis_aresetn    (rst_n),
        .s00_axis_tdata  (s_data[0]),
        .s00_axis_tstrb  (s_strb[0]),
        .s00_axis_tvalid (s_valid[0]),
        .s00_axis_tlast  (s_last[0]),
        .s00_axis_tready (n_trdy0),
        .s01_axis_tdata  (s_data[1]),
        .s01_axis_tstrb  (s_strb[1]),
        .s01_axis_tvalid (s_valid[1]),
        .s01_axis_tlast  (s_last[1]),
        .s01_axis_tready (n_trdy1),
        .m00_axis_tdata  (n_data),
        .m00_axis_tstrb  (n_strb),
        .m00_axis_tvalid (n_valid),
        .m00_axis_tlast  (n_last),
        .m00_axis_tready (m_ready),
        .grant_id        (n_gid),
        .busy            (n_busy),
        .pkt_cnt0        (n_cnt0),
        .pkt_cnt1        (n_cnt1)
    );

    // ---------------- monitor: downstream beats and grant starts ------------
    int            cyc = 0;
    logic          busy_d = 1'b0;
    logic [DW-1:0] q_data [$];
    logic [SW-1:0] q_strb [$];
    logic          q_last [$];
    int            q_cyc  [$];
    int            g_q    [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_strb.push_back(m_strb);
            q_last.push_back(m_last);
            q_cyc.push_back(cyc);
        end
        if (busy && !busy_d) g_q.push_back(int'(grant_id));
        busy_d <= busy;
    end

    // ---------------- checking ---------------------------------------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx,
                              input logic [DW-1:0] d, input logic [SW-1:0] st, input logic l);
        check({tag, "_present"}, 64'(q_data.size() > idx), 64'd1);
        if (q_data.size() > idx) begin
            check({tag, "_data"}, 64'(q_data[idx]), 64'(d));
            check({tag, "_strb"}, 64'(q_strb[idx]), 64'(st));
            check({tag, "_last"}, 64'(q_last[idx]), 64'(l));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            s_valid[p] = 1'b0;
            s_last[p]  = 1'b0;
            s_data[p]  = '0;
            s_strb[p]  = '0;
        end
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    // Present one packet on requester `port`; beat i carries base+i, strb i+1.
    task automatic send_pkt(input int port, input int nb, input logic [DW-1:0] base);
        for (int i = 0; i < nb; i++) begin
            bit acc;
            s_valid[port] = 1'b1;
            s_data[port]  = base + DW'(i);
            s_strb[port]  = SW'(i + 1);
            s_last[port]  = (i == nb - 1);
            acc = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (w_trdy[port]) begin
                    acc = 1'b1;
                    break;
                end
            end
            check($sformatf("accept_p%0d_b%0d", port, i), 64'(acc), 64'd1);
            tick();
        end
        s_valid[port] = 1'b0;
        s_last[port]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gbase;
        logic [DW-1:0] exp_alt [8];

        // ---------------- reset state ---------------------------------------
        rst_n   = 1'b0;
        m_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            s_valid[p] = 1'b1;   // requests during reset must not be granted
            s_last[p]  = 1'b0;
            s_data[p]  = 32'hFFFF_FFFF;
            s_strb[p]  = '1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_m_data",  64'(m_data), 0);
        check("rst_m_strb",  64'(m_strb), 0);
        check("rst_m_last",  64'(m_last), 0);
        check("rst_trdy0",   64'(w_trdy[0]), 0);
        check("rst_trdy1",   64'(w_trdy[1]), 0);
        check("rst_busy",    64'(busy), 0);
        check("rst_gid",     64'(grant_id), 1);
        check("rst_cnt0",    64'(cnt0), 0);
        check("rst_cnt1",    64'(cnt1), 0);
        apply_reset();

        // ---------------- single requester, cycle by cycle ------------------
        s_valid[0] = 1'b1; s_data[0] = 32'hA1; s_strb[0] = 4'hF; s_last[0] = 1'b0;
        #1;
        check("sr_idle_trdy0", 64'(w_trdy[0]), 0);
        check("sr_idle_busy",  64'(busy), 0);
        tick();
        #1;
        check("sr_g0_trdy0", 64'(w_trdy[0]), 1);
        check("sr_g0_trdy1", 64'(w_trdy[1]), 0);
        check("sr_g0_busy",  64'(busy), 1);
        check("sr_g0_gid",   64'(grant_id), 0);
        check("sr_g0_mval",  64'(m_valid), 0);
        tick();
        s_data[0] = 32'hA2;
        #1;
        check("sr_a1_mval", 64'(m_valid), 1);
        check("sr_a1_data", 64'(m_data), 64'hA1);
        check("sr_a1_last", 64'(m_last), 0);
        check("sr_a1_trdy1", 64'(w_trdy[1]), 0);
        tick();
        s_data[0] = 32'hA3; s_last[0] = 1'b1;
        #1;
        check("sr_a2_data", 64'(m_data), 64'hA2);
        check("sr_a2_trdy1", 64'(w_trdy[1]), 0);
        tick();
        s_valid[0] = 1'b0; s_last[0] = 1'b0;
        #1;
        check("sr_a3_data",  64'(m_data), 64'hA3);
        check("sr_a3_last",  64'(m_last), 1);
        check("sr_a3_busy",  64'(busy), 0);
        check("sr_a3_trdy0", 64'(w_trdy[0]), 0);
        tick();
        #1;
        check("sr_end_mval", 64'(m_valid), 0);

        // ---------------- tie after reset -----------------------------------
        apply_reset();
        base  = q_data.size();
        gbase = g_q.size();
        fork
            send_pkt(0, 2, 32'hB0);
            send_pkt(1, 2, 32'hC0);
        join
        drain();
        check_beat("tie0", base + 0, 32'hB0, 4'h1, 1'b0);
        check_beat("tie1", base + 1, 32'hB1, 4'h2, 1'b1);
        check_beat("tie2", base + 2, 32'hC0, 4'h1, 1'b0);
        check_beat("tie3", base + 3, 32'hC1, 4'h2, 1'b1);
        if (q_cyc.size() > base + 2)
            check("tie_bubble", 64'(q_cyc[base + 2] - q_cyc[base + 1]), 64'd2);
        check("tie_grants_n", 64'(g_q.size() - gbase), 64'd2);
        if (g_q.size() >= gbase + 2) begin
            check("tie_grant_a", 64'(g_q[gbase]), 0);
            check("tie_grant_b", 64'(g_q[gbase + 1]), 1);
        end

        // ---------------- alternation under continuous demand ---------------
        base  = q_data.size();
        gbase = g_q.size();
        fork
            begin send_pkt(0, 2, 32'h10); send_pkt(0, 2, 32'h30); end
            begin send_pkt(1, 2, 32'h20); send_pkt(1, 2, 32'h40); end
        join
        drain();
        exp_alt = '{32'h10, 32'h11, 32'h20, 32'h21, 32'h30, 32'h31, 32'h40, 32'h41};
        for (int i = 0; i < 8; i++)
            check_beat($sformatf("alt%0d", i), base + i, exp_alt[i], SW'(i % 2 + 1), 1'((i % 2) == 1));
        check("alt_grants_n", 64'(g_q.size() - gbase), 64'd4);
        if (g_q.size() >= gbase + 4)
            for (int i = 0; i < 4; i++)
                check($sformatf("alt_grant%0d", i), 64'(g_q[gbase + i]), 64'(i % 2));

        // ---------------- downstream backpressure ---------------------------
        base = q_data.size();
        fork
            send_pkt(0, 4, 32'hD0);
            begin
                repeat (3) @(posedge clk);
                #1;
                m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_mval",  64'(m_valid), 1);
                    check("bp_data",  64'(m_data), 64'hD1);
                    check("bp_trdy0", 64'(w_trdy[0]), 0);
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 4; i++)
            check_beat($sformatf("bp%0d", i), base + i, 32'hD0 + DW'(i), SW'(i + 1), 1'(i == 3));
        check("bp_count", 64'(q_data.size() - base), 64'd4);

        // ---------------- reset in the middle of a packet -------------------
        s_valid[0] = 1'b1; s_data[0] = 32'hE0; s_strb[0] = 4'h1; s_last[0] = 1'b0;
        tick();
        tick();
        s_data[0] = 32'hE1; s_strb[0] = 4'h2;
        tick();
        s_data[0] = 32'hE2; s_strb[0] = 4'h3;
        #1;
        check("mr_pre_data", 64'(m_data), 64'hE1);
        rst_n = 1'b0;
        #1;
        check("mr_mval",  64'(m_valid), 0);
        check("mr_data",  64'(m_data), 0);
        check("mr_strb",  64'(m_strb), 0);
        check("mr_last",  64'(m_last), 0);
        check("mr_busy",  64'(busy), 0);
        check("mr_gid",   64'(grant_id), 1);
        check("mr_trdy0", 64'(w_trdy[0]), 0);
        s_valid[0] = 1'b0; s_last[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("mr_post_busy", 64'(busy), 0);
        base  = q_data.size();
        gbase = g_q.size();
        send_pkt(1, 2, 32'hF0);
        drain();
        check_beat("mr0", base + 0, 32'hF0, 4'h1, 1'b0);
        check_beat("mr1", base + 1, 32'hF1, 4'h2, 1'b1);
        check("mr_count", 64'(q_data.size() - base), 64'd2);
        if (g_q.size() > gbase)
            check("mr_grant", 64'(g_q[gbase]), 1);

        // ---------------- packet statistics ---------------------------------
        apply_reset();
        for (int k = 0; k < 3; k++) send_pkt(1, 1, 32'h50 + DW'(k));
        drain();
        check("st_cnt1_3",    64'(cnt1),   STATS ? 64'd3 : 64'd0);
        check("st_cnt0_3",    64'(cnt0),   64'd0);
        check("st_w2_cnt1_3", 64'(n_cnt1), STATS ? 64'd3 : 64'd0);
        for (int k = 0; k < 2; k++) send_pkt(1, 1, 32'h60 + DW'(k));
        drain();
        check("st_cnt1_5",    64'(cnt1),   STATS ? 64'd5 : 64'd0);
        check("st_w2_cnt1_5", 64'(n_cnt1), STATS ? 64'd1 : 64'd0);
        check("st_w2_cnt0_5", 64'(n_cnt0), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_axis_rr_arbiter
